// File: rtl/alu_arb.sv
// alu_arb: two-port round-robin arbiter and sequencer for the shared ALU.
// Requests arrive on two valid/ready ports, are registered into a single
// issue stage (s1) that drives the ALU directly, and the combinational ALU
// result is captured one edge later into a 2-entry response FIFO belonging to
// the requester that issued it.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous discard of all in-flight work
//   req_*_0, req_*_1   request handshake, operands, select code and tag
//   rsp_*_0, rsp_*_1   response handshake, result and returned tag
//   alu_x/alu_y/alu_sel  operands to the ALU, alu_z its combinational result
module alu_arb #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid_0,
  output logic            req_ready_0,
  input  logic [XLEN-1:0] req_x_0,
  input  logic [XLEN-1:0] req_y_0,
  input  logic [3:0]      req_sel_0,
  input  logic [TAGW-1:0] req_tag_0,
  input  logic            req_valid_1,
  output logic            req_ready_1,
  input  logic [XLEN-1:0] req_x_1,
  input  logic [XLEN-1:0] req_y_1,
  input  logic [3:0]      req_sel_1,
  input  logic [TAGW-1:0] req_tag_1,
  output logic            rsp_valid_0,
  input  logic            rsp_ready_0,
  output logic [XLEN-1:0] rsp_z_0,
  output logic [TAGW-1:0] rsp_tag_0,
  output logic            rsp_valid_1,
  input  logic            rsp_ready_1,
  output logic [XLEN-1:0] rsp_z_1,
  output logic [TAGW-1:0] rsp_tag_1,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_z
);

  localparam int EW = XLEN + TAGW;

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] req_x [2];
  logic [XLEN-1:0] req_y [2];
  logic [3:0]      req_sel [2];
  logic [TAGW-1:0] req_tag [2];

  logic [1:0] mine;
  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] occ [2];

  logic            s1_valid_q, s1_valid_d;
  logic            s1_id_q, s1_id_d;
  logic [XLEN-1:0] s1_x_q, s1_x_d;
  logic [XLEN-1:0] s1_y_q, s1_y_d;
  logic [3:0]      s1_sel_q, s1_sel_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic            last_grant_q, last_grant_d;

  logic [EW-1:0] mem_q [2][2];
  logic [1:0]    wptr_q;
  logic [1:0]    rptr_q;
  logic [1:0]    count_q [2];

  assign req_valid  = {req_valid_1, req_valid_0};
  assign rsp_ready  = {rsp_ready_1, rsp_ready_0};
  assign req_x[0]   = req_x_0;
  assign req_x[1]   = req_x_1;
  assign req_y[0]   = req_y_0;
  assign req_y[1]   = req_y_1;
  assign req_sel[0] = req_sel_0;
  assign req_sel[1] = req_sel_1;
  assign req_tag[0] = req_tag_0;
  assign req_tag[1] = req_tag_1;

  // Per-port occupancy counts the op sitting in s1 plus the FIFO entries, so
  // a port can never hold more results than its FIFO can absorb. A pop in the
  // same cycle frees a slot early, which is what lets a full port keep
  // streaming at one op per cycle. Ties go to the port not granted last.
  // Ready is forced low while reset is asserted.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      mine[p] = s1_valid_q & (s1_id_q == p[0]);
      pop[p]  = (count_q[p] != 2'd0) & rsp_ready[p];
      push[p] = mine[p] & ~flush;
      occ[p]  = {1'b0, mine[p]} + count_q[p];
      elig[p] = ~flush & (({1'b0, occ[p]} - {2'b0, pop[p]}) < 3'd2);
    end
    grant[0] = rst_n & req_valid[0] & elig[0] &
               (~(req_valid[1] & elig[1]) | last_grant_q);
    grant[1] = rst_n & req_valid[1] & elig[1] &
               (~(req_valid[0] & elig[0]) | ~last_grant_q);
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  // Issue stage next state: load the granted request, otherwise hold the data
  // and just drop the valid bit. Flush leaves port 0 favoured for the next tie.
  always_comb begin
    s1_valid_d   = |grant;
    s1_id_d      = s1_id_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s1_sel_d     = s1_sel_q;
    s1_tag_d     = s1_tag_q;
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      s1_id_d      = 1'b0;
      s1_x_d       = req_x[0];
      s1_y_d       = req_y[0];
      s1_sel_d     = req_sel[0];
      s1_tag_d     = req_tag[0];
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      s1_id_d      = 1'b1;
      s1_x_d       = req_x[1];
      s1_y_d       = req_y[1];
      s1_sel_d     = req_sel[1];
      s1_tag_d     = req_tag[1];
      last_grant_d = 1'b1;
    end
    if (flush) begin
      last_grant_d = 1'b1;
    end
  end

  // Issue stage and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_sel_q     <= '0;
      s1_tag_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_sel_q     <= s1_sel_d;
      s1_tag_q     <= s1_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_x   = s1_x_q;
  assign alu_y   = s1_y_q;
  assign alu_sel = s1_sel_q;

  // Response FIFOs, one per port. The s1 result is written at the edge after
  // issue; simultaneous push and pop on one FIFO leave its count unchanged.
  // Flush resets the bookkeeping only; stale storage is never visible because
  // the count is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int e = 0; e < 2; e++) begin
          mem_q[p][e] <= '0;
        end
        count_q[p] <= 2'd0;
      end
      wptr_q <= 2'b00;
      rptr_q <= 2'b00;
    end else if (flush) begin
      for (int p = 0; p < 2; p++) begin
        count_q[p] <= 2'd0;
      end
      wptr_q <= 2'b00;
      rptr_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          mem_q[p][wptr_q[p]] <= {alu_z, s1_tag_q};
          wptr_q[p]           <= ~wptr_q[p];
        end
        if (pop[p]) begin
          rptr_q[p] <= ~rptr_q[p];
        end
        count_q[p] <= count_q[p] + {1'b0, push[p]} - {1'b0, pop[p]};
      end
    end
  end

  assign rsp_valid_0          = count_q[0] != 2'd0;
  assign rsp_valid_1          = count_q[1] != 2'd0;
  assign {rsp_z_0, rsp_tag_0} = mem_q[0][rptr_q[0]];
  assign {rsp_z_1, rsp_tag_1} = mem_q[1][rptr_q[1]];

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-port arbiter and sequencer for the shared integer ALU (`XLEN`-wide operands `x`/`y`, 4-bit `alusel`, combinational result `z`). It accepts operation requests from two requesters with valid/ready handshakes and grants the ALU round-robin. It registers operands into a single issue stage and returns each result, with the requester's tag, through a per-requester 2-entry response FIFO. It sits between the issue logic (port 0 = integer pipe, port 1 = address/branch unit) and the one `alu` instance.

## Interface
- `XLEN`, 64, operand/result width
- `TAGW`, 4, opaque request tag width, returned unchanged with the result
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous; discards all in-flight work
- `req_valid_i` (i=0,1)  in  1  request present
- `req_ready_i`  out  1  request accepted this cycle
- `req_x_i`, `req_y_i`  in  XLEN  operands
- `req_sel_i`  in  4  ALU select code (`SEL_*` from const.h), passed through uninterpreted
- `req_tag_i`  in  TAGW  tag
- `rsp_valid_i`  out  1  result available
- `rsp_ready_i`  in  1  consumer takes result
- `rsp_z_i`  out  XLEN  result
- `rsp_tag_i`  out  TAGW  tag of that result
- `alu_x`, `alu_y`  out  XLEN  to ALU `x`/`y`
- `alu_sel`  out  4  to ALU `alusel`
- `alu_z`  in  XLEN  from ALU `z` (combinational)

## Operation
- Issue stage registers: `s1_valid`, `s1_id`, `s1_x`, `s1_y`, `s1_sel`, `s1_tag`. `alu_x`/`alu_y`/`alu_sel` are driven directly from `s1_x`/`s1_y`/`s1_sel`.
- Per requester i:
  - `pop_i = rsp_valid_i & rsp_ready_i`.
  - `occ_i = (s1_valid & s1_id==i) + fifo_count_i`, range 0..2.
  - Eligible iff `occ_i - pop_i < 2` and `flush` is low.
- Grant:
  - If only one requester is valid and eligible, it is granted.
  - If both are, the one not named by `last_grant` is granted.
  - `req_ready_i` equals `grant_i`. It may depend combinationally on `req_valid_*`. `rsp_valid_*` never depends on `rsp_ready_*`.
- Accept (`req_valid_i & req_ready_i`):
  - The request's operands, sel and tag load into s1 with `s1_id=i` and `s1_valid=1`.
  - `last_grant` is set to i.
  - With no grant, `s1_valid` is set to 0; s1 data holds.
- Completion: when `s1_valid` is high, `{alu_z, s1_tag}` is pushed into FIFO[`s1_id`] at the clock edge. Push and pop on the same FIFO in the same cycle are both honoured. Overflow cannot occur by construction, and the bench asserts it.
- FIFO: 2 entries, in-order. `rsp_valid_i = fifo_count_i != 0`, and `rsp_z_i`/`rsp_tag_i` come from the head entry.
- `flush`:
  - At the edge, `s1_valid`, both FIFO counts and all pointers clear, and `last_grant` is set to 1.
  - No request is accepted in the flush cycle.
  - A push from s1 in that cycle is dropped.
- Select codes: the arbiter does not decode `alusel`. A code outside the `SEL_*` set yields an undefined result but still completes and returns its tag.
- Each requester's results are in order. There is no ordering between ports.

## Timing
- Reset (async, `rst_n` low):
  - `s1_valid=0`, `s1_*` data = 0, so `alu_x`/`alu_y`/`alu_sel` = 0.
  - FIFOs empty, `rsp_valid_*=0`, `rsp_z_*`/`rsp_tag_*` = 0.
  - `last_grant=1`, so port 0 wins the first tie.
  - `req_ready_*` are 0 while in reset. Reset mid-operation drops everything.
- Latency: accept at edge N → `rsp_valid_i` high in cycle N+1 (after edge N+1) when the FIFO was empty and not blocked. That is 2 edges from accept to consumable result.
- Throughput: one accept per cycle total, alternating ports under sustained contention.
- Backpressure: requester i may hold at most 2 operations (s1 + FIFO). A 3rd accept is possible only in a cycle where it pops.
- `req_ready_i` is low in any cycle where `req_valid_i` is low.

## Test plan
- Single op: port 0 `SEL_ADD` with x=5, y=7, tag=3, `rsp_ready_0=1` → `req_ready_0` in cycle 0; `rsp_valid_0` in cycle 2 with z=12, tag=3. Port 1 shows no response.
- Contention: both ports valid every cycle, port 0 `SEL_SUB` 10-3, port 1 `SEL_XOR` 0xF0^0x0F → grants alternate 0,1,0,1 starting with 0; results are 7 and 0xFF with matching tags.
- Backpressure: port 1 `rsp_ready_1=0`, 4 back-to-back `SEL_SLL` requests with y=1..4 → only 2 accepted, `req_ready_1` low afterwards. Port 0 is still granted every cycle. Raising `rsp_ready_1` drains in order and resumes accepts.
- Signed ops: `SEL_SLT` x=-1, y=1 → z=1. `SEL_SLTU` with the same operands → z=0. `SEL_SRA` x=0x8000_0000_0000_0000, y=4 → z=0xF800_0000_0000_0000.
- Flush: assert `flush` with s1 occupied and both FIFOs holding 1 entry → next cycle all `rsp_valid` are 0, no `req_ready` in the flush cycle, and the first later tie goes to port 0.
- Async reset mid-stream: drop `rsp_n` (sic `rst_n`) between edges with ops in flight → outputs clear immediately without waiting for a clock. After release, a fresh request completes with 2-cycle latency.
